// File: rtl/gf16_pkg.sv
// GF(2^4) field definitions shared by the syndrome datapath.
// Field polynomial x^4+x+1, primitive element alpha = 0x2.
package gf16_pkg;

   localparam logic [4:0] GF_POLY = 5'b10011;

   typedef logic [3:0] gf16_t;

   localparam gf16_t ALPHA_POW [0:14] = '{
      4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
      4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
   };

   function automatic gf16_t gf16_mul(input gf16_t a, input gf16_t b);
      gf16_t p;
      gf16_t t;
      p = '0;
      t = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ t;
         t = t[3] ? ((t << 1) ^ GF_POLY[3:0]) : (t << 1);
      end
      return p;
   endfunction

endpackage

// File: rtl/gf16_syn_cell.sv
// One syndrome accumulator: S <= S*alpha^j + sym (Horner step).
// The constant multiply is a fixed XOR matrix built at elaboration.
module gf16_syn_cell
   import gf16_pkg::*;
#(
   parameter gf16_t ALPHA = 4'h2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       acc,
   input  logic [3:0] sym,
   output logic [3:0] s
);

   localparam gf16_t COL0 = gf16_mul(ALPHA, 4'h1);
   localparam gf16_t COL1 = gf16_mul(ALPHA, 4'h2);
   localparam gf16_t COL2 = gf16_mul(ALPHA, 4'h4);
   localparam gf16_t COL3 = gf16_mul(ALPHA, 4'h8);

   gf16_t prod;

   assign prod = ({4{s[0]}} & COL0) ^
                 ({4{s[1]}} & COL1) ^
                 ({4{s[2]}} & COL2) ^
                 ({4{s[3]}} & COL3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         s <= '0;
      else if (load)
         s <= sym;
      else if (acc)
         s <= prod ^ sym;
   end

endmodule

// File: rtl/gf16_syndrome_calc.sv
// Streaming RS syndrome calculator over GF(16).
// Symbols arrive highest degree first; one Horner cell per syndrome.
module gf16_syndrome_calc
   import gf16_pkg::*;
#(
   parameter int NUM_SYN = 4,
   parameter int MAX_LEN = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_sym,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NUM_SYN-1:0] syn,
   output logic                 syn_zero,
   output logic                 len_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] count;
   logic [4:0] count_nxt;
   logic       accept;
   logic       load;
   logic       acc;

   assign in_ready  = rst_n & (state != HOLD);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid & in_ready;
   assign load      = accept & (state == IDLE);
   assign acc       = accept & (state == ACC);
   assign count_nxt = {1'b0, count} + 5'd1;
   assign syn_zero  = ~|syn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= '0;
         len_err <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  count <= 4'd1;
                  if (in_last) begin
                     state <= HOLD;
                  end else if (MAX_LEN == 1) begin
                     state   <= HOLD;
                     len_err <= 1'b1;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            ACC: begin
               if (accept) begin
                  count <= count_nxt[3:0];
                  if (in_last) begin
                     state <= HOLD;
                  end else if (count_nxt == 5'(MAX_LEN)) begin
                     // codeword overran: stop taking symbols
                     state   <= HOLD;
                     len_err <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state   <= IDLE;
                  len_err <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar j = 1; j <= NUM_SYN; j++) begin : g_cell
      gf16_syn_cell #(
         .ALPHA (ALPHA_POW[j])
      ) u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load),
         .acc   (acc),
         .sym   (in_sym),
         .s     (syn[4*j-1 -: 4])
      );
   end

endmodule

// File: tb/tb_gf16_syndrome_calc.sv
// Directed bench for gf16_syndrome_calc with hand-computed syndromes.
// Syndrome vectors are written {S4,S3,S2,S1}.
module tb_gf16_syndrome_calc;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_sym;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] syn;
   logic        syn_zero;
   logic        len_err;

   int checks;
   int failures;

   gf16_syndrome_calc #(
      .NUM_SYN (4),
      .MAX_LEN (15)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sym    (in_sym),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .syn       (syn),
      .syn_zero  (syn_zero),
      .len_err   (len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] s, input logic l);
      @(negedge clk);
      in_valid = 1'b1;
      in_sym   = s;
      in_last  = l;
      chk("in_ready_on_send", 16'(in_ready), 16'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] esyn,
                             input logic ezero, input logic eerr);
      @(negedge clk);
      chk({tag, "_out_valid"}, 16'(out_valid), 16'h1);
      chk({tag, "_syn"}, syn, esyn);
      chk({tag, "_syn_zero"}, 16'(syn_zero), 16'(ezero));
      chk({tag, "_len_err"}, 16'(len_err), 16'(eerr));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sym    = 4'h0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      #12;
      chk("rst_in_ready", 16'(in_ready), 16'h0);
      chk("rst_out_valid", 16'(out_valid), 16'h0);
      chk("rst_syn", syn, 16'h0000);
      chk("rst_syn_zero", 16'(syn_zero), 16'h1);
      chk("rst_len_err", 16'(len_err), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // single symbol
      send(4'h5, 1'b1);
      expect_out("single", 16'h5555, 1'b0, 1'b0);

      // polynomial x
      send(4'h1, 1'b0);
      send(4'h0, 1'b1);
      expect_out("poly_x", 16'h3842, 1'b0, 1'b0);

      // polynomial x^2 with consumer stalled
      send(4'h1, 1'b0);
      send(4'h0, 1'b0);
      send(4'h0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_sym   = 4'hF;
         in_last  = 1'b1;
         chk("stall_in_ready", 16'(in_ready), 16'h0);
         chk("stall_out_valid", 16'(out_valid), 16'h1);
         chk("stall_syn", syn, 16'h5C34);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      expect_out("poly_x2", 16'h5C34, 1'b0, 1'b0);

      // full-length all-zero codeword, then back-to-back
      for (int i = 0; i < 15; i++) send(4'h0, i == 14);
      expect_out("zero15", 16'h0000, 1'b1, 1'b0);
      send(4'h7, 1'b1);
      expect_out("after_zero", 16'h7777, 1'b0, 1'b0);

      // overlength: sum x^0..x^14 evaluates to zero at every alpha^j
      for (int i = 0; i < 15; i++) send(4'h1, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_sym   = 4'h1;
      chk("ovl_in_ready", 16'(in_ready), 16'h0);
      chk("ovl_out_valid", 16'(out_valid), 16'h1);
      chk("ovl_len_err", 16'(len_err), 16'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      expect_out("ovl", 16'h0000, 1'b1, 1'b1);
      @(negedge clk);
      chk("ovl_cleared_len_err", 16'(len_err), 16'h0);
      chk("ovl_idle_ready", 16'(in_ready), 16'h1);
      send(4'h3, 1'b1);
      expect_out("after_ovl", 16'h3333, 1'b0, 1'b0);

      // async reset mid-codeword
      send(4'h1, 1'b0);
      send(4'h1, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", 16'(in_ready), 16'h0);
      chk("arst_out_valid", 16'(out_valid), 16'h0);
      chk("arst_syn", syn, 16'h0000);
      chk("arst_syn_zero", 16'(syn_zero), 16'h1);
      chk("arst_len_err", 16'(len_err), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_no_partial", 16'(out_valid), 16'h0);
      send(4'h1, 1'b0);
      send(4'h0, 1'b1);
      expect_out("after_rst", 16'h3842, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gf16_syndrome_calc.md
Name: gf16_syndrome_calc

Overview:
- Streaming Reed-Solomon syndrome calculator over GF(2^4), field polynomial x^4+x+1, primitive element alpha = 0x2.
- Consumes received codeword symbols highest-degree first, one per accepted beat.
- Evaluates the received polynomial at alpha^1..alpha^NUM_SYN by Horner's rule, using one combinational GF(16) multiplier per syndrome.
- Sits directly downstream of the symbol source and upstream of the error locator; the team's GF(16) multiplier is its arithmetic core.

Parameters:
- NUM_SYN, 4, number of syndromes (2t); legal range 1..14.
- MAX_LEN, 15, maximum codeword length in symbols; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  symbol valid.
- in_ready  output  1  block can accept a symbol.
- in_sym  input  4  received symbol, GF(16) polynomial basis, bit0 = x^0.
- in_last  input  1  final (degree-0) symbol of the codeword.
- out_valid  output  1  syndromes valid.
- out_ready  input  1  consumer accepts the syndromes.
- syn  output  4*NUM_SYN  S_j occupies bits [4j-1:4(j-1)], j=1..NUM_SYN.
- syn_zero  output  1  all syndromes are zero (no detected error); valid with out_valid.
- len_err  output  1  codeword exceeded MAX_LEN; valid with out_valid.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, all S_j=0, symbol count=0, in_ready=0 while rst_n=0, out_valid=0, len_err=0, syn_zero=1.
- Accept: in_valid & in_ready on a rising edge. Output handoff: out_valid & out_ready.
- State IDLE: in_ready=1, out_valid=0.
  - On accept: S_j <= in_sym for all j (load; prior contents discarded); count <= 1.
  - If in_last, go to HOLD; else go to ACC.
- State ACC: in_ready=1.
  - On accept: S_j <= gfmul(S_j, alpha^j) XOR in_sym; count++.
  - If in_last, go to HOLD.
  - Else, if count+1 == MAX_LEN, go to HOLD and set len_err=1 (symbols beyond MAX_LEN are never accepted).
- State HOLD: in_ready=0, out_valid=1; syn, syn_zero and len_err stable.
  - On handoff: go to IDLE and clear len_err. in_ready returns to 1 the next cycle; there is no same-cycle bypass.
- Latency: out_valid asserts the cycle after the last symbol is accepted.
- Throughput: one symbol per cycle. Minimum one idle cycle between codewords (the HOLD handoff).
- Arithmetic:
  - All additions are XOR.
  - alpha^j constants are computed at elaboration from the field table: alpha^1..14 = 2,4,8,3,6,C,B,5,A,7,E,F,D,9.
  - Accumulator update is single-cycle combinational (one constant multiply plus XOR); no pipelining.
- syn_zero = NOR of all syn bits; it is combinational from registers.
- in_valid while in_ready=0 is ignored. in_sym and in_last are don't-care when in_valid=0.
- MAX_LEN=1 with in_last=0 on the first symbol: go straight from IDLE to HOLD with len_err=1.
- Reset asserted mid-codeword aborts it. After release, no partial result is ever presented.

Decomposition:
- Shared package gf16_pkg holds:
  - localparam GF_POLY = 5'b10011;
  - typedef gf16_t (logic [3:0]);
  - constant table ALPHA_POW[0:14];
  - function gf16_mul(a, b) for elaboration-time use.
- State enum {IDLE, ACC, HOLD} is local to the module.
- One sub-module: gf16_syn_cell, one per syndrome, instantiated NUM_SYN times via generate.
  - Holds the 4-bit register with load/accumulate enable.
  - Holds the constant-alpha^j multiplier.

Test Plan:
- Reset then single symbol 0x5 with in_last -> next cycle out_valid=1; syn S1..S4 = 5,5,5,5; syn_zero=0; len_err=0.
- Symbols [0x1, 0x0] (poly x) -> S1..S4 = 2,4,8,3.
- Symbols [0x1, 0x0, 0x0] -> S1..S4 = 4,3,C,5. Repeat with out_ready=0 for 5 cycles: syn stable, in_ready=0, no new symbols accepted.
- 15 zero symbols, last on the 15th -> all S=0, syn_zero=1, len_err=0. Back-to-back next codeword [0x7] with last -> S=7,7,7,7; no residue from the prior codeword.
- 16 symbols with in_last never set -> in_ready drops after the 15th accept; out_valid=1, len_err=1. After handoff, a clean codeword [0x3] with last gives S=3,3,3,3 and len_err=0.
- rst_n pulsed low asynchronously (mid-cycle) after 2 of 4 symbols -> outputs immediately at reset values. Fresh codeword [0x1, 0x0] yields S=2,4,8,3.
